// File: rtl/ch_queue_arbiter_pkg.sv
// Shared types and helpers for the ch_queue arbiter family.
package ch_queue_arbiter_pkg;

  localparam int unsigned CHQ_DATA_W = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  // Index of the off-th candidate when the search starts at base.
  function automatic int unsigned rr_index(input int unsigned base,
                                           input int unsigned off,
                                           input int unsigned n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/ch_queue_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid requester at or after ptr.
module ch_rr_picker
  import ch_queue_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  logic [IDX_W-1:0] k;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    k       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = IDX_W'(rr_index(32'(ptr_i), i, NUM_REQ));
      if (!any_o && valid_i[k]) begin
        any_o      = 1'b1;
        idx_o      = k;
        grant_o[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ch_queue_arbiter.sv
// Round-robin arbiter with burst locking feeding one ch_queue enqueue port
// through a single registered output stage.
module ch_queue_arbiter
  import ch_queue_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = CHQ_DATA_W,
  parameter int unsigned IDX_W   = 2,
  parameter int unsigned BURST   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        io_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] io_req_data,
  output logic [NUM_REQ-1:0]        io_req_ready,
  output logic                      io_enq_valid,
  output logic [DATA_W-1:0]         io_enq_data,
  output logic [IDX_W-1:0]          io_enq_src,
  input  logic                      io_enq_ready,
  output logic                      io_busy
);

  localparam int unsigned CNT_W = $clog2(BURST + 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vld_q, vld_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [IDX_W-1:0] src_q, src_d;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   win;
  logic               any;
  logic               load;
  logic               accept;
  logic [CNT_W-1:0]   cnt_n;
  logic [DATA_W-1:0]  win_data;

  ch_rr_picker #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_picker (
    .valid_i(io_req_valid),
    .ptr_i  (ptr_q),
    .grant_o(grant),
    .idx_o  (win),
    .any_o  (any)
  );

  assign load   = !vld_q | io_enq_ready;
  assign accept = any & load;

  // Reset gating keeps ready low while reset is held, independent of the clock.
  assign io_req_ready = (load & reset) ? grant : '0;

  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) win_data = io_req_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    data_d  = data_q;
    src_d   = src_q;
    cnt_n   = (state_q == ST_BURST && win == owner_q) ? cnt_q + 1'b1 : CNT_W'(1);
    if (accept) begin
      vld_d   = 1'b1;
      data_d  = win_data;
      src_d   = win;
      owner_d = win;
      if (cnt_n < CNT_W'(BURST)) begin
        ptr_d   = win;
        state_d = ST_BURST;
        cnt_d   = cnt_n;
      end else begin
        ptr_d   = win + 1'b1;
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    end else if (io_enq_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      src_q   <= src_d;
    end
  end

  assign io_enq_valid = vld_q;
  assign io_enq_data  = data_q;
  assign io_enq_src   = src_q;
  assign io_busy      = (state_q == ST_BURST);

endmodule

// File: tb/tb_ch_queue_arbiter.sv
// Directed bench: burst arbiter (BURST=2) and plain round-robin (BURST=1).
module tb_ch_queue_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  valid_a, valid_b;
  logic [15:0] data;
  logic        enq_ready;

  logic [3:0] ready_a, ready_b;
  logic       enq_valid_a, enq_valid_b;
  logic [3:0] enq_data_a, enq_data_b;
  logic [1:0] enq_src_a, enq_src_b;
  logic       busy_a, busy_b;

  int n_checks = 0;
  int n_pass   = 0;

  int exp_src[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

  ch_queue_arbiter #(.NUM_REQ(4), .DATA_W(4), .IDX_W(2), .BURST(2)) dut_a (
    .clk         (clk),
    .reset       (reset),
    .io_req_valid(valid_a),
    .io_req_data (data),
    .io_req_ready(ready_a),
    .io_enq_valid(enq_valid_a),
    .io_enq_data (enq_data_a),
    .io_enq_src  (enq_src_a),
    .io_enq_ready(enq_ready),
    .io_busy     (busy_a)
  );

  ch_queue_arbiter #(.NUM_REQ(4), .DATA_W(4), .IDX_W(2), .BURST(1)) dut_b (
    .clk         (clk),
    .reset       (reset),
    .io_req_valid(valid_b),
    .io_req_data (data),
    .io_req_ready(ready_b),
    .io_enq_valid(enq_valid_b),
    .io_enq_data (enq_data_b),
    .io_enq_src  (enq_src_b),
    .io_enq_ready(1'b1),
    .io_busy     (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [3:0] oh(input int i);
    return 4'b0001 << i;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    valid_a   = 4'b1111;
    valid_b   = 4'b1010;
    data      = 16'h8765;
    enq_ready = 1'b1;

    #2;
    check("rst_ready_a", 32'(ready_a), 32'h0);
    check("rst_enq_valid_a", 32'(enq_valid_a), 32'h0);
    check("rst_busy_a", 32'(busy_a), 32'h0);
    check("rst_enq_data_a", 32'(enq_data_a), 32'h0);
    check("rst_enq_src_a", 32'(enq_src_a), 32'h0);
    check("rst_ready_b", 32'(ready_b), 32'h0);
    step();
    check("rst_hold_enq_valid_a", 32'(enq_valid_a), 32'h0);
    check("rst_hold_ready_a", 32'(ready_a), 32'h0);

    @(negedge clk);
    reset = 1'b1;
    #1;
    check("first_ready_a", 32'(ready_a), 32'(oh(0)));
    check("first_ready_b", 32'(ready_b), 32'(oh(1)));

    for (int k = 0; k < 9; k++) begin
      step();
      check("burst_src", 32'(enq_src_a), 32'(exp_src[k]));
      check("burst_data", 32'(enq_data_a), 32'(exp_src[k] + 5));
      check("burst_valid", 32'(enq_valid_a), 32'h1);
      check("burst_busy", 32'(busy_a), 32'((k % 2) == 0));
      if (k < 8) check("burst_ready", 32'(ready_a), 32'(oh(exp_src[k+1])));
      if (k < 4) begin
        check("rr_src_b", 32'(enq_src_b), 32'(((k % 2) == 0) ? 1 : 3));
        check("rr_data_b", 32'(enq_data_b), 32'(((k % 2) == 0) ? 6 : 8));
      end
      check("rr_busy_b", 32'(busy_b), 32'h0);
    end

    // Backpressure with a beat from requester 2 held.
    valid_a = 4'b0100;
    #1;
    check("bp_first_ready", 32'(ready_a), 32'(oh(2)));
    step();
    check("bp_src", 32'(enq_src_a), 32'h2);
    check("bp_data", 32'(enq_data_a), 32'h7);
    enq_ready = 1'b0;
    data      = 16'h8965;
    #1;
    check("bp_stall_ready0", 32'(ready_a), 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_stall_ready", 32'(ready_a), 32'h0);
      check("bp_stall_src", 32'(enq_src_a), 32'h2);
      check("bp_stall_data", 32'(enq_data_a), 32'h7);
      check("bp_stall_valid", 32'(enq_valid_a), 32'h1);
    end
    enq_ready = 1'b1;
    #1;
    check("bp_reload_ready", 32'(ready_a), 32'(oh(2)));
    step();
    check("bp_reload_src", 32'(enq_src_a), 32'h2);
    check("bp_reload_data", 32'(enq_data_a), 32'h9);
    check("bp_reload_valid", 32'(enq_valid_a), 32'h1);
    check("bp_reload_busy", 32'(busy_a), 32'h0);

    // Owner drop: requester 1 starts a burst, then only 3 is valid.
    valid_a = 4'b0010;
    step();
    check("drop_src1", 32'(enq_src_a), 32'h1);
    check("drop_busy1", 32'(busy_a), 32'h1);
    valid_a = 4'b1000;
    #1;
    check("drop_ready3", 32'(ready_a), 32'(oh(3)));
    step();
    check("drop_src3", 32'(enq_src_a), 32'h3);
    check("drop_data3", 32'(enq_data_a), 32'h8);
    check("drop_busy3", 32'(busy_a), 32'h1);
    valid_a = 4'b1111;
    #1;
    check("drop_owner_ready", 32'(ready_a), 32'(oh(3)));
    step();
    check("drop_owner_src", 32'(enq_src_a), 32'h3);
    check("drop_owner_busy", 32'(busy_a), 32'h0);

    // Asynchronous reset in the middle of a burst.
    valid_a = 4'b0100;
    step();
    check("mid_src", 32'(enq_src_a), 32'h2);
    check("mid_busy", 32'(busy_a), 32'h1);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(enq_valid_a), 32'h0);
    check("mid_rst_busy", 32'(busy_a), 32'h0);
    check("mid_rst_src", 32'(enq_src_a), 32'h0);
    check("mid_rst_data", 32'(enq_data_a), 32'h0);
    check("mid_rst_ready", 32'(ready_a), 32'h0);
    @(negedge clk);
    reset   = 1'b1;
    valid_a = 4'b1111;
    #1;
    check("restart_ready", 32'(ready_a), 32'(oh(0)));
    step();
    check("restart_src", 32'(enq_src_a), 32'h0);
    check("restart_data", 32'(enq_data_a), 32'h5);
    check("restart_valid", 32'(enq_valid_a), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
